// File: rtl/trig_ctrl.sv
// ---------------------------------------------------------------------------
// TrigCtrl : trigger controller sequencing the ADC capture engine
//
// Watches the live ADC sample stream on one of two channels and detects a
// level crossing using a hysteresis band around a programmable level.
// Depending on the selected polarity, a rising and/or falling crossing
// produces a one-clock trigger request towards the capture engine. The
// request is only issued while armed. Arming happens after a post-arm
// holdoff, and an optional auto-fire kicks in when no edge arrives within
// AUTO_TIMEOUT samples. The MCU re-arms the controller after readout.
//
// Ports:
//   clk         sample/system clock
//   rst         asynchronous reset, active-high
//   cfg[31:0]   [7:0] level, [11:8] hyst, [13:12] edge polarity
//               (00 none, 01 rising, 10 falling, 11 both),
//               [14] source (0 = A, 1 = B), [15] auto-fire enable,
//               [31:16] holdoff length in samples
//   sample_a    ADC channel A sample
//   sample_b    ADC channel B sample
//   sample_en   one-clock strobe per sample tick
//   arm         one-clock re-arm strobe from the MCU side
//   waiting     capture engine is waiting for a trigger
//   trigger_req one-clock trigger pulse to the capture engine
//   armed       controller is armed and looking for a trigger
//   triggered   controller has fired and is waiting for re-arm
//   auto_fired  the most recent fire was caused by the timeout
//   trig_count  number of trigger pulses issued (statistics build only)
//
// Build option:
//   TRIG_STATS_EN  when defined, trig_count is a saturating 16-bit count
//                  of trigger pulses. When undefined, trig_count is tied
//                  to zero and no counter is built.
// ---------------------------------------------------------------------------
module trig_ctrl #(
    parameter int                DW           = 8,
    parameter int                HOLD_W       = 16,
    parameter int                TO_W         = 24,
    parameter logic [TO_W-1:0]   AUTO_TIMEOUT = 24'd1000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   cfg,
    input  logic [DW-1:0] sample_a,
    input  logic [DW-1:0] sample_b,
    input  logic          sample_en,
    input  logic          arm,
    input  logic          waiting,
    output logic          trigger_req,
    output logic          armed,
    output logic          triggered,
    output logic          auto_fired,
    output logic [15:0]   trig_count
);

    // Threshold arithmetic is carried out one bit wider than a sample so
    // that level+hyst can be detected as overflowing the sample range.
    localparam int XW = DW + 1;
    localparam logic [XW-1:0]   SAT_MAX = XW'((1 << DW) - 1);
    localparam logic [TO_W-1:0] TO_LAST = AUTO_TIMEOUT - TO_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HOLDOFF = 2'b01,
        ARMED   = 2'b10,
        FIRED   = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Configuration field decode
    // ------------------------------------------------------------------
    logic [7:0]  w_level;
    logic [3:0]  w_hyst;
    logic [1:0]  w_edgeSel;
    logic        w_srcB;
    logic        w_autoEn;
    logic [15:0] w_holdoff;

    assign w_level   = cfg[7:0];
    assign w_hyst    = cfg[11:8];
    assign w_edgeSel = cfg[13:12];
    assign w_srcB    = cfg[14];
    assign w_autoEn  = cfg[15];
    assign w_holdoff = cfg[31:16];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic              r_above;
    logic              r_hit;
    logic [HOLD_W-1:0] r_holdCnt;
    logic [TO_W-1:0]   r_toCnt;
    logic              r_trigReq;
    logic              r_autoFired;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [DW-1:0] w_sample;
    logic [XW-1:0] w_sampleX;
    logic [XW-1:0] w_levelX;
    logic [XW-1:0] w_hystX;
    logic [XW-1:0] w_sum;
    logic [XW-1:0] w_hi;
    logic [XW-1:0] w_lo;
    logic          w_newAbove;
    logic          w_rise;
    logic          w_fall;
    logic          w_edgeHit;
    logic          w_timeoutHit;

    state_t        w_nextState;
    logic          w_fire;
    logic          w_autoFire;
    logic          w_holdLoad;
    logic          w_holdDec;
    logic          w_toClear;
    logic          w_toInc;

    // Pick the watched channel and widen everything to the threshold
    // width so the band edges can be computed without wrap-around.
    assign w_sample  = w_srcB ? sample_b : sample_a;
    assign w_sampleX = XW'(w_sample);
    assign w_levelX  = XW'(w_level);
    assign w_hystX   = XW'(w_hyst);
    assign w_sum     = w_levelX + w_hystX;

    // Upper band edge saturates at full scale, lower band edge at zero.
    assign w_hi = (w_sum > SAT_MAX) ? SAT_MAX : w_sum;
    assign w_lo = (w_levelX > w_hystX) ? (w_levelX - w_hystX) : '0;

    // Hysteresis comparator. The upper test is checked first so that with
    // a zero-width band a sample equal to the level counts as above.
    // Inside the band the previous decision is kept.
    always_comb begin
        w_newAbove = r_above;
        if (w_sampleX >= w_hi) begin
            w_newAbove = 1'b1;
        end else if (w_sampleX <= w_lo) begin
            w_newAbove = 1'b0;
        end
    end

    // An edge is a real change of the above flag, so moving the level or
    // band alone cannot trigger unless the flag actually toggles.
    assign w_rise    = ~r_above & w_newAbove;
    assign w_fall    = r_above & ~w_newAbove;
    assign w_edgeHit = (w_edgeSel[0] & w_rise) | (w_edgeSel[1] & w_fall);

    // Auto-fire fires on the sample tick that would complete the
    // timeout window.
    assign w_timeoutHit = sample_en & w_autoEn & (r_toCnt == TO_LAST);

    // Comparator register. It runs in every state so the hysteresis
    // history never has gaps, and it registers a one-clock edge flag that
    // the state machine consumes on the following clock. Keeping the edge
    // as a registered pulse gives the two-clock strobe-to-trigger latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_above <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            if (sample_en) begin
                r_above <= w_newAbove;
            end
            r_hit <= sample_en & w_edgeHit;
        end
    end

    // Next-state and control decode for the trigger sequencer. A re-arm
    // strobe wins over everything, including a fire that would otherwise
    // happen in the same clock, and always restarts the holdoff. In
    // HOLDOFF the last counted sample moves straight to ARMED so that armed
    // rises right after the final holdoff sample; a zero holdoff arms on
    // the clock after the strobe. In ARMED an edge takes priority over the
    // timeout, and nothing happens at all while the capture engine is not
    // waiting, which also freezes the timeout counter.
    always_comb begin
        w_nextState = r_state;
        w_fire      = 1'b0;
        w_autoFire  = 1'b0;
        w_holdLoad  = 1'b0;
        w_holdDec   = 1'b0;
        w_toClear   = 1'b0;
        w_toInc     = 1'b0;

        if (arm) begin
            w_nextState = HOLDOFF;
            w_holdLoad  = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nextState = IDLE;
                end

                HOLDOFF: begin
                    if (r_holdCnt == '0) begin
                        w_nextState = ARMED;
                        w_toClear   = 1'b1;
                    end else if (sample_en) begin
                        if (r_holdCnt == HOLD_W'(1)) begin
                            w_nextState = ARMED;
                            w_toClear   = 1'b1;
                        end else begin
                            w_holdDec = 1'b1;
                        end
                    end
                end

                ARMED: begin
                    if (waiting) begin
                        if (r_hit) begin
                            w_nextState = FIRED;
                            w_fire      = 1'b1;
                            w_autoFire  = 1'b0;
                        end else if (w_timeoutHit) begin
                            w_nextState = FIRED;
                            w_fire      = 1'b1;
                            w_autoFire  = 1'b1;
                        end else if (sample_en) begin
                            w_toInc = 1'b1;
                        end
                    end
                end

                FIRED: begin
                    w_nextState = FIRED;
                end

                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // State register together with the holdoff and timeout counters and
    // the registered trigger outputs. The fire decision is registered so
    // the trigger pulse is glitch-free and lasts exactly one clock; since
    // firing always leaves ARMED, two back-to-back pulses cannot occur.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_holdCnt   <= '0;
            r_toCnt     <= '0;
            r_trigReq   <= 1'b0;
            r_autoFired <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_trigReq <= w_fire;

            if (w_fire) begin
                r_autoFired <= w_autoFire;
            end

            if (w_holdLoad) begin
                r_holdCnt <= HOLD_W'(w_holdoff);
            end else if (w_holdDec) begin
                r_holdCnt <= r_holdCnt - HOLD_W'(1);
            end

            if (w_toClear) begin
                r_toCnt <= '0;
            end else if (w_toInc) begin
                r_toCnt <= r_toCnt + TO_W'(1);
            end
        end
    end

    assign trigger_req = r_trigReq;
    assign armed       = (r_state == ARMED);
    assign triggered   = (r_state == FIRED);
    assign auto_fired  = r_autoFired;

`ifdef TRIG_STATS_EN
    logic [15:0] r_trigCount;

    // Trigger statistics: counts every issued pulse, sticks at full scale
    // instead of wrapping, and is only cleared by reset (re-arm keeps it).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trigCount <= '0;
        end else if (w_fire && (r_trigCount != 16'hFFFF)) begin
            r_trigCount <= r_trigCount + 16'd1;
        end
    end

    assign trig_count = r_trigCount;
`else
    assign trig_count = '0;
`endif

endmodule

// File: tb/tb_trig_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trig_ctrl : self-checking bench for trig_ctrl
//
// A behavioural model tracks the comparator decision, the trigger sequence
// and the fire count per clock and is compared against the DUT after every
// clock. Directed scenarios cover latency, hysteresis, holdoff, auto-fire,
// priorities and reset; a randomized phase follows. The DUT is built with
// a short auto-timeout so timeout behaviour is reachable quickly.
// ---------------------------------------------------------------------------
module tb_trig_ctrl;

    localparam int TIMEOUT = 16;

    localparam int PH_IDLE  = 0;
    localparam int PH_HOLD  = 1;
    localparam int PH_ARMED = 2;
    localparam int PH_FIRED = 3;

    logic        clk;
    logic        rst;
    logic [31:0] cfg;
    logic [7:0]  sample_a;
    logic [7:0]  sample_b;
    logic        sample_en;
    logic        arm;
    logic        waiting;
    logic        trigger_req;
    logic        armed;
    logic        triggered;
    logic        auto_fired;
    logic [15:0] trig_count;

    int total = 0;
    int bad   = 0;
    int calls = 0;
    int pulses = 0;
    int lastPulseCycle = -1;
    logic prevReq = 1'b0;

    // Model state
    int mPhase;
    int mHoldLeft;
    int mWaited;
    int mFires;
    bit mAbove;
    bit mEdgeSeen;
    bit mReq;
    bit mAuto;

    trig_ctrl #(
        .DW(8),
        .HOLD_W(16),
        .TO_W(24),
        .AUTO_TIMEOUT(24'd16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg(cfg),
        .sample_a(sample_a),
        .sample_b(sample_b),
        .sample_en(sample_en),
        .arm(arm),
        .waiting(waiting),
        .trigger_req(trigger_req),
        .armed(armed),
        .triggered(triggered),
        .auto_fired(auto_fired),
        .trig_count(trig_count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mkCfg(input int level, input int hyst, input int edgeSel,
                                          input int src, input int autoEn, input int holdoff);
        return {holdoff[15:0], autoEn[0], src[0], edgeSel[1:0], hyst[3:0], level[7:0]};
    endfunction

    function automatic void modelReset();
        mPhase    = PH_IDLE;
        mHoldLeft = 0;
        mWaited   = 0;
        mFires    = 0;
        mAbove    = 1'b0;
        mEdgeSeen = 1'b0;
        mReq      = 1'b0;
        mAuto     = 1'b0;
    endfunction

    function automatic void fireModel(input bit byTimeout);
        mPhase = PH_FIRED;
        mReq   = 1'b1;
        mAuto  = byTimeout;
        if (mFires < 65535) mFires++;
    endfunction

    // Advance the model across one rising edge using the inputs currently
    // applied. The sequencer reacts to an edge seen on the previous sample
    // tick; the comparator then evaluates the current tick.
    function automatic void modelEdge();
        int level;
        int hyst;
        int edgeSel;
        int autoEn;
        int holdoff;
        int s;
        int hi;
        int lo;
        bit newAbove;
        level   = int'(cfg[7:0]);
        hyst    = int'(cfg[11:8]);
        edgeSel = int'(cfg[13:12]);
        autoEn  = int'(cfg[15]);
        holdoff = int'(cfg[31:16]);
        mReq = 1'b0;

        if (arm) begin
            mPhase    = PH_HOLD;
            mHoldLeft = holdoff;
        end else if (mPhase == PH_HOLD) begin
            if (mHoldLeft == 0) begin
                mPhase  = PH_ARMED;
                mWaited = 0;
            end else if (sample_en) begin
                mHoldLeft--;
                if (mHoldLeft == 0) begin
                    mPhase  = PH_ARMED;
                    mWaited = 0;
                end
            end
        end else if (mPhase == PH_ARMED && waiting) begin
            if (mEdgeSeen) begin
                fireModel(1'b0);
            end else if (sample_en) begin
                mWaited++;
                if (autoEn == 1 && mWaited == TIMEOUT) fireModel(1'b1);
            end
        end

        if (sample_en) begin
            s  = cfg[14] ? int'(sample_b) : int'(sample_a);
            hi = level + hyst;
            if (hi > 255) hi = 255;
            lo = level - hyst;
            if (lo < 0) lo = 0;
            newAbove = mAbove;
            if (s >= hi) newAbove = 1'b1;
            else if (s <= lo) newAbove = 1'b0;
            mEdgeSeen = (edgeSel[0] && !mAbove && newAbove) ||
                        (edgeSel[1] && mAbove && !newAbove);
            mAbove = newAbove;
        end else begin
            mEdgeSeen = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        int expCount;
`ifdef TRIG_STATS_EN
        expCount = mFires;
`else
        expCount = 0;
`endif
        checkOutput("trigger_req", {31'd0, trigger_req}, {31'd0, mReq});
        checkOutput("armed", {31'd0, armed}, (mPhase == PH_ARMED) ? 32'd1 : 32'd0);
        checkOutput("triggered", {31'd0, triggered}, (mPhase == PH_FIRED) ? 32'd1 : 32'd0);
        checkOutput("auto_fired", {31'd0, auto_fired}, {31'd0, mAuto});
        checkOutput("trig_count", {16'd0, trig_count}, expCount);
    endtask

    // Drive one clock worth of inputs, step the model, then observe the
    // DUT on the falling edge after the rising edge.
    task automatic applyStimulus(input logic [7:0] a, input bit en, input bit armIn);
        int thisCycle;
        thisCycle = calls;
        sample_a  = a;
        sample_en = en;
        arm       = armIn;
        modelEdge();
        @(posedge clk);
        @(negedge clk);
        calls++;
        if (trigger_req === 1'b1) begin
            pulses++;
            lastPulseCycle = thisCycle + 1;
        end
        checkAll();
        checkOutput("req_back_to_back", {31'd0, prevReq & trigger_req}, 32'd0);
        prevReq = trigger_req;
    endtask

    task automatic sampleTick(input logic [7:0] a);
        applyStimulus(a, 1'b1, 1'b0);
        applyStimulus(a, 1'b0, 1'b0);
        applyStimulus(a, 1'b0, 1'b0);
    endtask

    task automatic armPulse();
        applyStimulus(sample_a, 1'b0, 1'b1);
    endtask

    task automatic idleCycle();
        applyStimulus(sample_a, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        rst       = 1'b1;
        sample_en = 1'b0;
        arm       = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        prevReq = 1'b0;
    endtask

    initial begin
        int p0;
        int strobeCycle;
        logic [7:0] a;
        rst       = 1'b1;
        cfg       = 32'd0;
        sample_a  = 8'd0;
        sample_b  = 8'd0;
        sample_en = 1'b0;
        arm       = 1'b0;
        waiting   = 1'b0;
        strobeCycle = 0;
        doReset();

        // Rising edge on a ramp with a zero holdoff
        $display("[TB] rising edge ramp");
        cfg      = mkCfg(128, 4, 1, 0, 0, 0);
        waiting  = 1'b1;
        sample_a = 8'd100;
        armPulse();
        idleCycle();
        checkOutput("ramp_armed", {31'd0, armed}, 32'd1);
        for (int v = 100; v <= 160; v++) begin
            if (v == 132) strobeCycle = calls;
            sampleTick(8'(v));
        end
        checkOutput("ramp_pulses", pulses, 32'd1);
        checkOutput("ramp_latency", lastPulseCycle - strobeCycle, 32'd2);
        checkOutput("ramp_triggered", {31'd0, triggered}, 32'd1);
        checkOutput("ramp_auto", {31'd0, auto_fired}, 32'd0);

        // Noise inside the hysteresis band must not fire
        $display("[TB] hysteresis");
        sampleTick(8'd120);
        p0 = pulses;
        armPulse();
        idleCycle();
        for (int i = 0; i < 10; i++) begin
            sampleTick(8'd129);
            sampleTick(8'd127);
        end
        checkOutput("noise_quiet", pulses - p0, 32'd0);
        sampleTick(8'd124);
        sampleTick(8'd132);
        checkOutput("noise_one_pulse", pulses - p0, 32'd1);

        // Holdoff of ten samples
        $display("[TB] holdoff");
        cfg = mkCfg(128, 4, 1, 0, 0, 10);
        sampleTick(8'd100);
        p0 = pulses;
        armPulse();
        for (int i = 1; i <= 15; i++) begin
            a = (i == 5 || i == 15) ? 8'd140 : 8'd100;
            sampleTick(a);
            if (i == 9)  checkOutput("hold_armed_9", {31'd0, armed}, 32'd0);
            if (i == 10) checkOutput("hold_armed_10", {31'd0, armed}, 32'd1);
            if (i == 14) checkOutput("hold_ignored", pulses - p0, 32'd0);
        end
        checkOutput("hold_fire", pulses - p0, 32'd1);

        // Auto-fire on the sixteenth armed sample
        $display("[TB] auto fire");
        cfg = mkCfg(128, 4, 1, 0, 1, 0);
        sampleTick(8'd0);
        p0 = pulses;
        armPulse();
        idleCycle();
        for (int i = 1; i <= 16; i++) begin
            sampleTick(8'd0);
            if (i == 15) checkOutput("auto_early", pulses - p0, 32'd0);
        end
        checkOutput("auto_pulse", pulses - p0, 32'd1);
        checkOutput("auto_flag", {31'd0, auto_fired}, 32'd1);

        cfg = mkCfg(128, 4, 1, 0, 0, 0);
        p0 = pulses;
        armPulse();
        idleCycle();
        for (int i = 0; i < 100; i++) sampleTick(8'd0);
        checkOutput("auto_off_quiet", pulses - p0, 32'd0);
        checkOutput("auto_off_armed", {31'd0, armed}, 32'd1);

        // Edge and timeout in the same clock: edge wins
        $display("[TB] priorities");
        cfg = mkCfg(128, 4, 1, 0, 1, 0);
        armPulse();
        idleCycle();
        p0 = pulses;
        for (int i = 0; i < 14; i++) sampleTick(8'd100);
        applyStimulus(8'd140, 1'b1, 1'b0);
        applyStimulus(8'd140, 1'b1, 1'b0);
        applyStimulus(8'd140, 1'b0, 1'b0);
        checkOutput("prio_edge_pulse", pulses - p0, 32'd1);
        checkOutput("prio_edge_auto", {31'd0, auto_fired}, 32'd0);

        // Re-arm coincident with a fire suppresses the pulse
        cfg = mkCfg(128, 4, 1, 0, 0, 5);
        sampleTick(8'd100);
        armPulse();
        for (int i = 0; i < 5; i++) sampleTick(8'd100);
        checkOutput("prio_arm_ready", {31'd0, armed}, 32'd1);
        p0 = pulses;
        applyStimulus(8'd140, 1'b1, 1'b0);
        applyStimulus(8'd140, 1'b0, 1'b1);
        checkOutput("prio_arm_nopulse", pulses - p0, 32'd0);
        checkOutput("prio_arm_unarmed", {31'd0, armed}, 32'd0);
        checkOutput("prio_arm_nofire", {31'd0, triggered}, 32'd0);

        // Timeout frozen while the capture engine is not waiting
        cfg = mkCfg(128, 4, 1, 0, 1, 0);
        sampleTick(8'd100);
        armPulse();
        idleCycle();
        p0 = pulses;
        for (int i = 0; i < 10; i++) sampleTick(8'd100);
        waiting = 1'b0;
        for (int i = 1; i <= 50; i++) sampleTick((i == 20) ? 8'd140 : 8'd100);
        checkOutput("freeze_quiet", pulses - p0, 32'd0);
        checkOutput("freeze_armed", {31'd0, armed}, 32'd1);
        waiting = 1'b1;
        for (int i = 0; i < 5; i++) sampleTick(8'd100);
        checkOutput("freeze_resume_early", pulses - p0, 32'd0);
        sampleTick(8'd100);
        checkOutput("freeze_resume_fire", pulses - p0, 32'd1);
        checkOutput("freeze_auto", {31'd0, auto_fired}, 32'd1);

        // Reset while the trigger pulse is high
        $display("[TB] reset and statistics");
        cfg = mkCfg(128, 4, 1, 0, 0, 0);
        sampleTick(8'd100);
        armPulse();
        idleCycle();
        applyStimulus(8'd140, 1'b1, 1'b0);
        applyStimulus(8'd140, 1'b0, 1'b0);
        checkOutput("rst_pre_req", {31'd0, trigger_req}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_req_drop", {31'd0, trigger_req}, 32'd0);
        checkOutput("rst_idle_armed", {31'd0, armed}, 32'd0);
        checkOutput("rst_idle_trig", {31'd0, triggered}, 32'd0);
        doReset();

        for (int k = 0; k < 3; k++) begin
            sampleTick(8'd100);
            armPulse();
            idleCycle();
            sampleTick(8'd140);
        end
`ifdef TRIG_STATS_EN
        checkOutput("stats_three", {16'd0, trig_count}, 32'd3);
`else
        checkOutput("stats_off", {16'd0, trig_count}, 32'd0);
`endif

        // Randomized traffic against the model
        $display("[TB] random phase");
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                cfg = mkCfg(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                            int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            end
            waiting  = ($urandom_range(0, 7) != 0);
            sample_b = 8'($urandom_range(0, 255));
            applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trig_ctrl.md
Name: trig_ctrl

Overview:
- Trigger controller that sequences the ADC capture engine.
- Watches the live ADC sample stream and detects a level crossing with hysteresis, programmable edge polarity and channel select.
- Enforces a post-arm holdoff and can auto-fire on timeout.
- Issues a one-cycle trigger_req to the capture engine's trigger input. Re-arm comes from the MCU/SPI side after readout.

Parameters:
- DW, 8, ADC sample width.
- HOLD_W, 16, holdoff counter width (samples).
- TO_W, 24, auto-timeout counter width.
- AUTO_TIMEOUT, 24'd1000000, samples in ARMED before auto-fire.

Ports:
- clk  input  1  sample/system clock (PLL clock domain)
- rst  input  1  asynchronous reset, active-high
- cfg  input  32  [7:0] level, [11:8] hyst, [13:12] edge (00 none, 01 rising, 10 falling, 11 both), [14] src (0=A, 1=B), [15] auto_en, [31:16] holdoff (samples)
- sample_a  input  DW  ADC channel A sample
- sample_b  input  DW  ADC channel B sample
- sample_en  input  1  one-clk strobe per sample tick from the sample divider
- arm  input  1  one-clk re-arm strobe (MCU readout done)
- waiting  input  1  capture engine is waiting for a trigger
- trigger_req  output  1  one-clk trigger pulse
- armed  output  1  state==ARMED
- triggered  output  1  state==FIRED
- auto_fired  output  1  last fire was caused by timeout
- trig_count  output  16  trigger event count (optional feature)

Behaviour:
- **Reset (async, rst high):**
  - State=IDLE.
  - All outputs 0; counters 0; comparator flag "above"=0; sample register 0.
- **Comparator (updates only on sample_en):**
  - s = src ? sample_b : sample_a.
  - hi = min(level+hyst, 255); lo = max(level-hyst, 0). Compute in DW+1 bits and saturate.
  - above<=1 if s>=hi; above<=0 if s<=lo; else hold. If hi==lo==level, s>=level wins.
  - rise = above 0->1; fall = above 1->0.
  - edge_hit = (edge[0]&rise) | (edge[1]&fall). edge==00 never hits.
  - Comparator runs in every state, so hysteresis history is continuous.
- **Latency:** trigger_req is high exactly 2 clk after the sample_en cycle carrying the crossing sample (1 clk comparator register, 1 clk output register).
- **State machine (IDLE, HOLDOFF, ARMED, FIRED):**
  - IDLE: arm -> HOLDOFF, holdoff counter loaded with cfg[31:16].
  - HOLDOFF: counter decrements on sample_en. At 0 -> ARMED. holdoff==0 gives ARMED on the next clk. Edges are ignored.
  - ARMED: timeout counter cleared on entry, increments on sample_en while waiting=1.
    - edge_hit & waiting -> trigger_req pulse, auto_fired<=0, FIRED.
    - Else if auto_en & count==AUTO_TIMEOUT-1 on sample_en -> trigger_req pulse, auto_fired<=1, FIRED.
    - waiting=0: edges ignored, timeout counter frozen.
  - FIRED: hold until arm -> HOLDOFF. auto_fired holds until the next fire.
- **Boundaries:**
  - Edge and timeout in the same cycle: edge wins, auto_fired=0.
  - arm in ARMED or HOLDOFF: restart holdoff; arm has priority over a same-cycle fire (no trigger_req).
  - cfg changes take effect on the next sample_en. Level/hyst changes never generate a fire by themselves unless the above-flag actually toggles.
  - trigger_req is never high for 2 consecutive clks.
  - rst mid-holdoff or mid-pulse: trigger_req drops immediately, state=IDLE.

Optional Feature:
- TRIG_STATS_EN defined: trig_count is a 16-bit counter, +1 per trigger_req, saturating at 16'hFFFF, cleared by rst only.
- Undefined: trig_count tied to 0 and no counter logic is synthesised.

Test Plan:
- Rising edge: cfg level=128, hyst=4, edge=01, holdoff=0; arm; waiting=1; ramp A 100->160 step 1 per sample_en -> one trigger_req 2 clk after the sample=132 strobe; triggered=1, auto_fired=0.
- Hysteresis/noise: level=128, hyst=4, edge=01; A toggles 129/127 -> no trigger_req. Then A=124 followed by A=132 -> exactly one pulse.
- Holdoff: holdoff=10; arm; crossing at sample 5 -> ignored. Crossing at sample 15 -> fires. armed rises after exactly 10 sample_en.
- Auto: AUTO_TIMEOUT=16, auto_en=1, A constant 0 -> pulse on the 16th sample_en in ARMED, auto_fired=1. auto_en=0 -> no pulse after 100 samples.
- Priority: same-cycle edge and timeout -> auto_fired=0. arm coincident with fire -> no pulse, state HOLDOFF. waiting=0 for 50 samples -> timeout frozen.
- Reset and stats: assert rst 1 clk after a fire -> trigger_req=0 and state IDLE immediately. With TRIG_STATS_EN, 3 fires -> trig_count=3.
